// File: rtl/crypto_dec_pipe.sv
// crypto_dec_pipe: three-stage pipelined byte decryptor with a rolling key stream.
// Stages: D1 rotate right by ROT, D2 XOR with (KEY + k), D3 subtract ADD_C.
// Optional sticky input-parity checker enabled by defining CRYPTO_DEC_PARITY_EN.
module crypto_dec_pipe #(
  parameter logic [7:0]  KEY   = 8'hA5,
  parameter int unsigned ROT   = 3,
  parameter logic [7:0]  ADD_C = 8'h3C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       resync,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] key_idx
`ifdef CRYPTO_DEC_PARITY_EN
  ,
  input  logic       in_parity,
  output logic       par_err
`endif
);

  logic       stall;
  logic       accept;
  logic [7:0] k_now;
  logic [15:0] rot_dbl;
  logic [7:0] x1;

  logic       s1_valid, s2_valid, s3_valid;
  logic [7:0] s1_data, s2_data, s3_data;
  logic [7:0] s1_k;

  assign stall     = s3_valid && !out_ready;
  assign in_ready  = !stall;
  assign accept    = in_valid && in_ready;
  // A resync on the accept cycle makes that byte use index 0.
  assign k_now     = resync ? '0 : key_idx;
  assign rot_dbl   = {in_data, in_data} >> ROT;
  assign x1        = rot_dbl[7:0];
  assign out_valid = s3_valid;
  assign out_data  = s3_data;

  // Pipeline registers: shift together when not stalled, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_data  <= '0;
      s2_data  <= '0;
      s3_data  <= '0;
      s1_k     <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= x1;
        s1_k    <= k_now;
      end
      s2_valid <= s1_valid;
      s2_data  <= s1_data ^ (KEY + s1_k);
      s3_valid <= s2_valid;
      s3_data  <= s2_data - ADD_C;
    end
  end

  // Key-stream index: resync wins regardless of stall; otherwise advance per accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_idx <= '0;
    end else if (resync) begin
      key_idx <= accept ? 8'd1 : 8'd0;
    end else if (accept) begin
      key_idx <= key_idx + 8'd1;
    end
  end

`ifdef CRYPTO_DEC_PARITY_EN
  // Sticky parity error on any accepted byte whose parity bit disagrees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err <= 1'b0;
    end else if (accept && ((^in_data) != in_parity)) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_crypto_dec_pipe.sv
// Self-checking bench for crypto_dec_pipe: vector table plus hand sequences,
// with a queue scoreboard popped on every output handshake.
module tb_crypto_dec_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       resync = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [7:0] key_idx;
`ifdef CRYPTO_DEC_PARITY_EN
  logic       in_parity = 1'b0;
  logic       par_err;
  logic       par_bad = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mk = '0;

  always #5 clk = ~clk;

  crypto_dec_pipe #(.KEY(8'hA5), .ROT(3), .ADD_C(8'h3C)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .resync(resync),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_idx(key_idx)
`ifdef CRYPTO_DEC_PARITY_EN
    , .in_parity(in_parity), .par_err(par_err)
`endif
  );

  typedef struct {
    logic [7:0] din;
    logic       rs;
    logic [7:0] exp;
  } vec_t;

  function automatic logic [7:0] dec(input logic [7:0] d, input logic [7:0] k);
    logic [7:0] r;
    logic [7:0] ks;
    r  = (d >> 3) | (d << 5);
    ks = 8'hA5 + k;
    return (r ^ ks) - 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every output handshake must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_emit", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    resync = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    mk = '0;
    rst = 1'b1;
  endtask

  // Drive one byte until accepted (bounded), then push its expected plaintext.
  task automatic send(input logic [7:0] d, input logic rs, input logic use_exp,
                      input logic [7:0] exp);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    resync   = rs;
`ifdef CRYPTO_DEC_PARITY_EN
    in_parity = (^d) ^ par_bad;
`endif
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(use_exp ? exp : dec(d, rs ? 8'd0 : mk));
      mk = rs ? 8'd1 : mk + 8'd1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    resync   = 1'b0;
    in_data  = 8'($urandom);
    chk("key_idx_after_send", {24'd0, key_idx}, {24'd0, mk});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  vec_t vt[5];
  logic [7:0] e0;

  initial begin
    vt[0] = '{din: 8'h00, rs: 1'b0, exp: 8'h6C};
    vt[1] = '{din: 8'hFF, rs: 1'b0, exp: 8'h1A};
    vt[2] = '{din: 8'h01, rs: 1'b0, exp: 8'h4E};
    vt[3] = '{din: 8'h3C, rs: 1'b1, exp: 8'hE6};
    vt[4] = '{din: 8'hCC, rs: 1'b0, exp: 8'h03};

    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_key_idx", {24'd0, key_idx}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    do_reset();

    // Single byte latency: out_valid rises on the third edge counted from accept
    send(8'hCC, 1'b0, 1'b1, 8'h00);
    chk("lat_s1_no_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_s2_no_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {24'd0, out_data}, 32'h00);
    chk("lat_key_idx", {24'd0, key_idx}, 32'd1);
    drain();

    // Back-to-back from key 0: consecutive outputs with no gap
    do_reset();
    send(8'hCC, 1'b0, 1'b1, 8'h00);
    send(8'hCC, 1'b0, 1'b1, 8'h03);
    send(8'hCC, 1'b0, 1'b1, 8'h02);
    chk("b2b_v0", {31'd0, out_valid}, 32'd1);
    chk("b2b_d0", {24'd0, out_data}, 32'h00);
    @(posedge clk); #1;
    chk("b2b_v1", {31'd0, out_valid}, 32'd1);
    chk("b2b_d1", {24'd0, out_data}, 32'h03);
    @(posedge clk); #1;
    chk("b2b_v2", {31'd0, out_valid}, 32'd1);
    chk("b2b_d2", {24'd0, out_data}, 32'h02);

    // Vector table continuing from key 3, including a resync+accept entry
    for (int i = 0; i < 5; i++) begin
      send(vt[i].din, vt[i].rs, 1'b1, vt[i].exp);
    end
    drain();
    chk("table_key_idx", {24'd0, key_idx}, 32'd2);

    // Stall: fill with three bytes, hold for five cycles, resync mid-stall
    out_ready = 1'b0;
    e0 = dec(8'h11, mk);
    send(8'h11, 1'b0, 1'b0, 8'h00);
    send(8'h22, 1'b0, 1'b0, 8'h00);
    send(8'h33, 1'b0, 1'b0, 8'h00);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_data", {24'd0, out_data}, {24'd0, e0});
      if (i == 1) resync = 1'b1;
      @(posedge clk); #1;
      resync = 1'b0;
    end
    in_valid = 1'b0;
    mk = '0;
    chk("stall_resync_key", {24'd0, key_idx}, 32'd0);
    chk("stall_queue_held", exp_q.size(), 32'd3);
    out_ready = 1'b1;
    drain();

    // Resync together with accept at key 7
    do_reset();
    for (int i = 0; i < 7; i++) send(8'($urandom), 1'b0, 1'b0, 8'h00);
    chk("pre_resync_key", {24'd0, key_idx}, 32'd7);
    send(8'hCC, 1'b1, 1'b1, 8'h00);
    chk("resync_acc_key", {24'd0, key_idx}, 32'd1);

    // 255 more bytes: index wraps back to 0
    for (int i = 0; i < 255; i++) send(8'($urandom), 1'b0, 1'b0, 8'h00);
    chk("wrap_key_idx", {24'd0, key_idx}, 32'd0);
    drain();

    // Reset with two bytes in flight
    send(8'h77, 1'b0, 1'b0, 8'h00);
    send(8'h88, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", {24'd0, out_data}, 32'd0);
    chk("midrst_key_idx", {24'd0, key_idx}, 32'd0);
    exp_q.delete();
    mk = '0;
    @(posedge clk); #3;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_emit", {31'd0, out_valid}, 32'd0);
    end
    send(8'hCC, 1'b0, 1'b1, 8'h00);
    drain();

`ifdef CRYPTO_DEC_PARITY_EN
    do_reset();
    chk("par_rst", {31'd0, par_err}, 32'd0);
    par_bad = 1'b1;
    send(8'h01, 1'b0, 1'b0, 8'h00);
    par_bad = 1'b0;
    chk("par_set", {31'd0, par_err}, 32'd1);
    send(8'h03, 1'b0, 1'b0, 8'h00);
    drain();
    chk("par_sticky", {31'd0, par_err}, 32'd1);
    do_reset();
    chk("par_cleared", {31'd0, par_err}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
